// File: rtl/booth_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_pipe_ctrl
// Purpose  : Pipeline sequencer for an 8-bit radix-4 Booth multiplier.
//            Accepts operand pairs on a valid/ready handshake, recodes the
//            multiplier into Booth digits, and drives the partial-product
//            load/clear strobes and the enables of the two add stages.
//            Per-stage valid bits give full backpressure, so the datapath
//            sustains one product per cycle and stalls without loss.
// Ports    : clk        - rising-edge clock
//            clr        - synchronous active-low reset
//            in_valid   - operand pair valid
//            in_ready   - controller accepts operands this cycle
//            mcand      - multiplicand (two's complement)
//            mplier     - multiplier (two's complement)
//            flush      - synchronous pipeline flush, active-high
//            out_ready  - consumer accepts result
//            out_valid  - stage-3 result valid
//            pp_load    - load strobes for partial-product registers
//            pp_clr     - clear for partial-product registers
//            booth_code - registered Booth digits, digit i at [3i+2:3i]
//            mcand_q    - registered multiplicand aligned with booth_code
//            sum_en     - stage-2 pair-sum register enable
//            fin_en     - stage-3 final-sum register enable
//            inflight   - number of valid stages (0..3)
// Revision : 1.0 - initial release
// ============================================================================
module booth_pipe_ctrl #(
    parameter int N_PP  = 4,   // only 4 is supported (8-bit operands)
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          mcand,
    input  logic [7:0]          mplier,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N_PP-1:0]     pp_load,
    output logic                pp_clr,
    output logic [3*N_PP-1:0]   booth_code,
    output logic [7:0]          mcand_q,
    output logic                sum_en,
    output logic                fin_en,
    output logic [CNT_W-1:0]    inflight
);

    logic               r_v1;
    logic               r_v2;
    logic               r_v3;
    logic [3*N_PP-1:0]  r_booth;
    logic [7:0]         r_mcand;
    logic [CNT_W-1:0]   r_inflight;

    logic               w_run;
    logic               w_fin_en;
    logic               w_sum_en;
    logic               w_in_ready;
    logic               w_acc;
    logic               w_v1_nxt;
    logic               w_v2_nxt;
    logic               w_v3_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2*N_PP:0]    w_mp_ext;
    logic [3*N_PP-1:0]  w_booth_nxt;

    // Pipe only advances when out of reset and not flushing; this single
    // term forces every enable and in_ready low in both cases.
    assign w_run = clr & ~flush;

    // Enables resolve from the output end backwards: a stage may move when
    // the stage after it is empty or is itself moving this cycle.
    assign w_fin_en   = w_run & r_v2 & (~r_v3 | out_ready);
    assign w_sum_en   = w_run & r_v1 & (~r_v2 | w_fin_en);
    assign w_in_ready = w_run & (~r_v1 | w_sum_en);
    assign w_acc      = in_valid & w_in_ready;

    always_comb begin
        w_v1_nxt = w_acc | (r_v1 & ~w_sum_en);
        w_v2_nxt = w_sum_en | (r_v2 & ~w_fin_en);
        w_v3_nxt = w_fin_en | (r_v3 & ~out_ready);
        if (flush) begin
            w_v1_nxt = 1'b0;
            w_v2_nxt = 1'b0;
            w_v3_nxt = 1'b0;
        end
    end

    assign w_cnt_nxt = CNT_W'(w_v1_nxt) + CNT_W'(w_v2_nxt) + CNT_W'(w_v3_nxt);

    // Appending a zero below the LSB supplies the implicit mplier[-1]=0, so
    // each digit is simply a 3-bit window stepping by two bits.
    assign w_mp_ext = {mplier, 1'b0};

    for (genvar gi = 0; gi < N_PP; gi++) begin : g_booth
        assign w_booth_nxt[3*gi+2:3*gi] = w_mp_ext[2*gi+2:2*gi];
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_booth    <= '0;
            r_mcand    <= '0;
            r_inflight <= '0;
        end else begin
            r_v1       <= w_v1_nxt;
            r_v2       <= w_v2_nxt;
            r_v3       <= w_v3_nxt;
            r_inflight <= w_cnt_nxt;
            if (w_acc) begin
                r_booth <= w_booth_nxt;
                r_mcand <= mcand;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign pp_load    = {N_PP{w_acc}};
    assign pp_clr     = ~clr | flush;
    assign sum_en     = w_sum_en;
    assign fin_en     = w_fin_en;
    assign out_valid  = r_v3;
    assign booth_code = r_booth;
    assign mcand_q    = r_mcand;
    assign inflight   = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_booth_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_pipe_ctrl
// Purpose  : Self-checking bench for booth_pipe_ctrl. A slot-occupancy
//            model of the three-stage pipe is compared with the DUT every
//            cycle; directed scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_pipe_ctrl;

    localparam int c_half = 5;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  pp_load;
    logic        pp_clr;
    logic [11:0] booth_code;
    logic [7:0]  mcand_q;
    logic        sum_en;
    logic        fin_en;
    logic [2:0]  inflight;

    int n_checks = 0;
    int n_errors = 0;

    booth_pipe_ctrl #(.N_PP(4), .CNT_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mcand      (mcand),
        .mplier     (mplier),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .pp_load    (pp_load),
        .pp_clr     (pp_clr),
        .booth_code (booth_code),
        .mcand_q    (mcand_q),
        .sum_en     (sum_en),
        .fin_en     (fin_en),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #c_half clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Booth digits from the multiplier by plain arithmetic on an integer.
    function automatic logic [11:0] booth_of(input logic [7:0] mp);
        int x;
        logic [11:0] bc;
        x  = int'(mp) * 2;
        bc = '0;
        for (int i = 0; i < 4; i++)
            bc = bc | 12'(((x >> (2 * i)) & 7) << (3 * i));
        return bc;
    endfunction

    // Value represented by a set of Booth digits.
    function automatic int booth_val(input logic [11:0] bc);
        int v;
        logic [2:0] d;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            d = bc[3*i +: 3];
            v = v + (-2 * int'(d[2]) + int'(d[1]) + int'(d[0])) * (4 ** i);
        end
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    logic [3:1]  m_occ = '0;
    logic [11:0] m_bc  = '0;
    logic [7:0]  m_mq  = '0;
    logic [7:0]  m_mp  = '0;
    logic        m_have = 1'b0;
    logic [3:1]  n_occ = '0;
    logic [11:0] n_bc  = '0;
    logic [7:0]  n_mq  = '0;
    logic [7:0]  n_mp  = '0;
    logic        n_have = 1'b0;

    always @(negedge clk) begin
        logic [3:1] occ;
        logic e_ir, e_acc, e_se, e_fe, e_pc;
        occ  = m_occ;
        e_ir = 1'b0; e_acc = 1'b0; e_se = 1'b0; e_fe = 1'b0; e_pc = 1'b1;
        n_bc = m_bc; n_mq = m_mq; n_mp = m_mp; n_have = m_have;
        if (!clr) begin
            occ = '0; n_bc = '0; n_mq = '0; n_have = 1'b0;
        end else if (flush) begin
            occ = '0;
        end else begin
            e_pc = 1'b0;
            // retire, then let each item slide into a free slot ahead of it
            if (occ[3] && out_ready) occ[3] = 1'b0;
            if (!occ[3] && occ[2]) begin occ[3] = 1'b1; occ[2] = 1'b0; e_fe = 1'b1; end
            if (!occ[2] && occ[1]) begin occ[2] = 1'b1; occ[1] = 1'b0; e_se = 1'b1; end
            e_ir = !occ[1];
            if (e_ir && in_valid) begin
                e_acc = 1'b1;
                occ[1] = 1'b1;
                n_bc = booth_of(mplier);
                n_mq = mcand;
                n_mp = mplier;
                n_have = 1'b1;
            end
        end
        n_occ = occ;

        chk("m_out_valid",  32'(out_valid),  32'(m_occ[3]));
        chk("m_inflight",   32'(inflight),   32'(m_occ[1]) + 32'(m_occ[2]) + 32'(m_occ[3]));
        chk("m_booth_code", 32'(booth_code), 32'(m_bc));
        chk("m_mcand_q",    32'(mcand_q),    32'(m_mq));
        chk("m_in_ready",   32'(in_ready),   32'(e_ir));
        chk("m_pp_load",    32'(pp_load),    32'({4{e_acc}}));
        chk("m_pp_clr",     32'(pp_clr),     32'(e_pc));
        chk("m_sum_en",     32'(sum_en),     32'(e_se));
        chk("m_fin_en",     32'(fin_en),     32'(e_fe));
        if (m_have)
            chk("m_booth_value", 32'(booth_val(booth_code)), 32'(int'($signed(m_mp))));
    end

    always @(posedge clk) begin
        m_occ = n_occ; m_bc = n_bc; m_mq = n_mq; m_mp = n_mp; m_have = n_have;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int sent;
    int n_out;

    initial begin
        clr = 1'b0; in_valid = 1'b1; mcand = 8'h11; mplier = 8'h33;
        flush = 1'b0; out_ready = 1'b1;

        // reset held two cycles with in_valid asserted
        tick(); tick();
        #2;
        chk("rst_in_ready",   32'(in_ready),   32'h0);
        chk("rst_pp_load",    32'(pp_load),    32'h0);
        chk("rst_pp_clr",     32'(pp_clr),     32'h1);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_inflight",   32'(inflight),   32'h0);
        chk("rst_booth_code", 32'(booth_code), 32'h000);

        // recode and latency, cycle 0 accept
        tick(); clr = 1'b1; in_valid = 1'b1; mcand = 8'h07; mplier = 8'h5A;
        #2; chk("lat_pp_load_c0", 32'(pp_load), 32'hF);
        tick(); in_valid = 1'b0;
        #2; chk("lat_booth_c1", 32'(booth_code), 32'h4EC);
        chk("lat_mcand_c1", 32'(mcand_q), 32'h07);
        chk("lat_sum_en_c1", 32'(sum_en), 32'h1);
        chk("lat_outv_c1", 32'(out_valid), 32'h0);
        tick(); #2;
        chk("lat_fin_en_c2", 32'(fin_en), 32'h1);
        chk("lat_outv_c2", 32'(out_valid), 32'h0);
        tick(); #2; chk("lat_outv_c3", 32'(out_valid), 32'h1);
        tick(); #2; chk("lat_outv_c4", 32'(out_valid), 32'h0);

        // negative multipliers
        tick(); in_valid = 1'b1; mplier = 8'h80;
        tick(); mplier = 8'hFF;
        #2; chk("neg_booth_80", 32'(booth_code), 32'h800);
        tick(); in_valid = 1'b0;
        #2; chk("neg_booth_FF", 32'(booth_code), 32'hFFE);
        repeat (4) tick();

        // backpressure: 5 items, consumer stalls cycles 3..7
        sent = 0; n_out = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (sent < 5);
            mcand     = 8'h20 + 8'(sent);
            mplier    = 8'h13 * 8'(sent + 1);
            #2;
            if (c >= 3 && c < 8) begin
                chk("bp_in_ready", 32'(in_ready), 32'h0);
                chk("bp_inflight", 32'(inflight), 32'h3);
                chk("bp_outv_held", 32'(out_valid), 32'h1);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) n_out++;
        end
        in_valid = 1'b0;
        chk("bp_results", 32'(n_out), 32'd5);
        chk("bp_sent", 32'(sent), 32'd5);

        // flush with three items in flight
        tick(); in_valid = 1'b1; out_ready = 1'b1; mplier = 8'h01;
        tick(); mplier = 8'h02;
        tick(); mplier = 8'h5A; mcand = 8'h3C;
        tick(); flush = 1'b1; mplier = 8'h80; mcand = 8'h99;
        #2;
        chk("fl_pp_clr", 32'(pp_clr), 32'h1);
        chk("fl_in_ready", 32'(in_ready), 32'h0);
        chk("fl_pp_load", 32'(pp_load), 32'h0);
        chk("fl_inflight_pre", 32'(inflight), 32'h3);
        tick(); flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("fl_out_valid", 32'(out_valid), 32'h0);
        chk("fl_inflight", 32'(inflight), 32'h0);
        chk("fl_in_ready_after", 32'(in_ready), 32'h1);
        chk("fl_booth_hold", 32'(booth_code), 32'h4EC);
        chk("fl_mcand_hold", 32'(mcand_q), 32'h3C);

        // reset mid-stream with two items in flight
        tick(); in_valid = 1'b1; out_ready = 1'b0; mplier = 8'h11;
        tick(); mplier = 8'h22;
        tick(); in_valid = 1'b0; clr = 1'b0;
        #2;
        chk("mr_inflight_pre", 32'(inflight), 32'h2);
        tick(); clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mplier = 8'h5A;
        #2;
        chk("mr_inflight", 32'(inflight), 32'h0);
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_accept", 32'(pp_load), 32'hF);
        tick(); in_valid = 1'b0;
        #2; chk("mr_booth", 32'(booth_code), 32'h4EC);
        chk("mr_outv_c1", 32'(out_valid), 32'h0);
        tick(); #2; chk("mr_outv_c2", 32'(out_valid), 32'h0);
        tick(); #2; chk("mr_outv_c3", 32'(out_valid), 32'h1);
        tick(); #2; chk("mr_outv_c4", 32'(out_valid), 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_pipe_ctrl.md
Name: booth_pipe_ctrl

Overview:
Pipeline sequencer for the 8-bit radix-4 Booth multiplier. It accepts operand pairs over a valid/ready handshake and recodes the multiplier into four Booth digits. It drives the load and clear strobes of the four partial-product registers and the enables of the two downstream add stages. It tracks per-stage valid bits with full backpressure, so the datapath sustains one product per cycle and stalls cleanly.

Parameters:
N_PP, 4, number of partial products and Booth digits; fixed for 8-bit operands; any other value is unsupported.
CNT_W, 3, width of the in-flight counter.

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands this cycle
mcand  in  8  multiplicand (two's complement)
mplier  in  8  multiplier (two's complement)
flush  in  1  synchronous pipeline flush, active-high
out_ready  in  1  consumer accepts result
out_valid  out  1  stage-3 result valid
pp_load  out  4  load strobe to partial-product registers 0..3
pp_clr  out  1  active-high clear to partial-product registers
booth_code  out  12  registered Booth digits; digit i at [3i+2:3i]
mcand_q  out  8  registered multiplicand aligned with booth_code
sum_en  out  1  stage-2 (pp0+pp1, pp2+pp3) register enable
fin_en  out  1  stage-3 (final sum) register enable
inflight  out  CNT_W  number of valid stages (0..3)

Behaviour:
- Reset: sampled on rising clk while clr=0.
  - v1, v2, v3, booth_code, mcand_q are all 0.
  - out_valid=0, inflight=0, in_ready=0, pp_load=0, sum_en=0, fin_en=0, pp_clr=1.
  - Reset mid-operation discards all in-flight items.
- Stage valid bits: v1 means partial products loaded; v2 means pair sums valid; v3 means result valid. out_valid=v3.
- Enables (combinational, evaluated when clr=1 and flush=0):
  - fin_en = v2 & (~v3 | out_ready)
  - sum_en = v1 & (~v2 | fin_en)
  - in_ready = ~v1 | sum_en
  - acc = in_valid & in_ready
  - pp_load = {4{acc}}
- Valid update on each edge:
  - v1 <= acc | (v1 & ~sum_en)
  - v2 <= sum_en | (v2 & ~fin_en)
  - v3 <= fin_en | (v3 & ~(out_ready & v3))
- Booth recode: on acc, booth_code[3i+2:3i] <= {mplier[2i+1], mplier[2i], mplier[2i-1]} with mplier[-1]=0, and mcand_q <= mcand. Both hold otherwise.
- Digit meaning: 000/111=0, 001/010=+1, 011=+2, 100=-2, 101/110=-1. Downstream expansion to 9-bit partial products is outside this block.
- Latency: operands accepted in cycle 0 give out_valid=1 in cycle 3 with no stall. Throughput is 1 per cycle.
- Backpressure: if out_ready=0 with v3=1, stages fill in order 3, 2, 1. in_ready drops only once v1, v2 and v3 are all 1. No valid item is ever overwritten or dropped.
- out_valid/result are held stable while out_ready=0.
- flush=1 (clr=1):
  - Forces in_ready=0, pp_load=0, sum_en=0, fin_en=0, pp_clr=1 that cycle.
  - Next edge: v1=v2=v3=0.
  - booth_code and mcand_q hold.
  - flush takes priority over any simultaneous handshake; an in_valid in that cycle is not accepted.
- pp_clr = ~clr | flush, combinational; 0 otherwise.
- inflight = v1+v2+v3, registered from the next-state valids, so it matches the valid bits after each edge.
- Simultaneous accept and drain of a full pipe (all v=1, out_ready=1, in_valid=1): all stages advance, the new item is accepted, and inflight stays 3.

Test Plan:
- Reset: clr=0 for 2 cycles with in_valid=1 -> in_ready=0, pp_load=0, pp_clr=1, out_valid=0, inflight=0, booth_code=0x000.
- Recode and latency: accept mcand=0x07, mplier=0x5A in cycle 0 with out_ready=1 -> pp_load=4'hF in cycle 0; booth_code=0x4EC from cycle 1; sum_en=1 in cycle 1; fin_en=1 in cycle 2; out_valid=1 only in cycle 3.
- Negative edge case: mplier=0x80 -> booth_code=0x800 (digit3=100, -2). mplier=0xFF -> booth_code=0xFFF... all digits 111 except digit0={1,1,0}=110, so expect 0xFFE.
- Backpressure: stream 5 back-to-back items, hold out_ready=0 from cycle 3 -> inflight reaches 3, in_ready=0 from cycle 3 on, the 4th item stalls. Releasing out_ready -> results emerge in order, one per cycle, none lost.
- Flush: 3 items in flight, flush=1 for 1 cycle while in_valid=1 -> pp_clr=1, no accept that cycle; next cycle out_valid=0, inflight=0, in_ready=1.
- Reset mid-stream: clr=0 for one cycle with inflight=2 -> all valids clear; the next accepted item emerges exactly 3 cycles after acceptance.
